// File: rtl/fire6_squeeze_ram_if.sv
// fire6_squeeze_ram_if: sample capture, read port and status bundle between
// the fire6 squeeze stage, the feature-map buffer and the fire6 expand stage.
// master = producer/consumer side (squeeze + expand), slave = the buffer.
interface fire6_squeeze_ram_if #(
  parameter int WIDTH = 16,
  parameter int CH    = 64,
  parameter int WOUT  = 16
);
  localparam int AW = $clog2(CH * WOUT * WOUT);

  logic             wr_sample;
  logic [WIDTH-1:0] ofm_in [0:CH-1];
  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             ram_feedback;
  logic             fmap_done;
  logic             overflow;
  logic [31:0]      chksum;

  modport master (
    output wr_sample, ofm_in, rd_en, rd_addr,
    input  rd_data, rd_valid, ram_feedback, fmap_done, overflow, chksum
  );

  modport slave (
    input  wr_sample, ofm_in, rd_en, rd_addr,
    output rd_data, rd_valid, ram_feedback, fmap_done, overflow, chksum
  );
endinterface

// File: rtl/fire6_squeeze_ram.sv
// fire6_squeeze_ram: captures one CH-wide squeeze output vector per sample
// strobe and serializes it, one channel per cycle, into a pixel-major
// feature-map RAM (word = pixel*CH + channel). After WOUT*WOUT pixels it
// pulses ram_feedback and holds fmap_done. Registered read-first read port.
// Optional macro FIRE6_SQZ_RAM_CHKSUM_EN adds a 32-bit running sum of all
// written words on chksum; otherwise chksum is tied to 0.
module fire6_squeeze_ram #(
  parameter int WIDTH = 16,
  parameter int CH    = 64,
  parameter int WOUT  = 16
) (
  input  logic                clk,
  input  logic                rst,
  fire6_squeeze_ram_if.slave  bus
);
  localparam int NPIX  = WOUT * WOUT;
  localparam int DEPTH = CH * NPIX;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(CH);
  localparam int PW    = $clog2(NPIX);

  localparam logic [CW-1:0] CH_LAST  = CW'(CH - 1);
  localparam logic [PW:0]   PIX_LAST = (PW+1)'(NPIX - 1);

  // Address is a plain concatenation {pixel, channel}; only valid for 2^n CH.
  if ((CH & (CH - 1)) != 0) begin : g_ch_pow2_chk
    $fatal(1, "fire6_squeeze_ram: CH must be a power of two");
  end

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                     state, state_n;
  logic [PW:0]                pix_cnt;
  logic [CW-1:0]              ch_cnt;
  logic [CH-1:0][WIDTH-1:0]   hold;
  logic                       accept, wr_en, drop, last_ch, last_pix, frame_end;
  logic [AW-1:0]              wr_addr;
  logic [WIDTH-1:0]           wr_data;
  logic                       rd_in_range;

  logic [WIDTH-1:0]           mem [DEPTH];

  logic [WIDTH-1:0]           rd_data_q;
  logic                       rd_valid_q, ram_feedback_q, fmap_done_q, overflow_q;

  assign last_ch   = (ch_cnt == CH_LAST);
  assign last_pix  = (pix_cnt == PIX_LAST);
  assign frame_end = wr_en && last_ch && last_pix;
  assign wr_addr   = {pix_cnt[PW-1:0], ch_cnt};
  assign wr_data   = hold[ch_cnt];

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Next-state and per-cycle control: accept in IDLE, write every SHIFT cycle
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    wr_en   = 1'b0;
    drop    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.wr_sample) begin
          accept  = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        wr_en = 1'b1;
        drop  = bus.wr_sample;
        if (last_ch) state_n = last_pix ? DONE : IDLE;
      end
      DONE: begin
        drop = bus.wr_sample;
      end
      default: state_n = IDLE;
    endcase
  end

  // Channel/pixel counters; frozen in DONE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ch_cnt  <= '0;
      pix_cnt <= '0;
    end else if (accept) begin
      ch_cnt <= '0;
    end else if (wr_en) begin
      if (last_ch) begin
        ch_cnt  <= '0;
        pix_cnt <= pix_cnt + 1'b1;
      end else begin
        ch_cnt <= ch_cnt + 1'b1;
      end
    end
  end

  // Hold bank, one lane per channel, loaded only on an accepted sample
  for (genvar c = 0; c < CH; c++) begin : g_hold
    always_ff @(posedge clk) begin
      if (accept) hold[c] <= bus.ofm_in[c];
    end
  end

  // Feature-map RAM write port (contents survive reset)
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Out-of-range reads only exist when DEPTH is not a power of two
  if (DEPTH == (1 << AW)) begin : g_rd_full
    assign rd_in_range = 1'b1;
  end else begin : g_rd_part
    assign rd_in_range = ({1'b0, bus.rd_addr} < (AW+1)'(DEPTH));
  end

  // Registered read port; same-address write is not visible until next read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en) rd_data_q <= rd_in_range ? mem[bus.rd_addr] : '0;
    end
  end

  // Frame status: one-cycle feedback pulse, sticky done and overflow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_feedback_q <= 1'b0;
      fmap_done_q    <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      ram_feedback_q <= frame_end;
      fmap_done_q    <= fmap_done_q | frame_end;
      overflow_q     <= overflow_q | drop;
    end
  end

`ifdef FIRE6_SQZ_RAM_CHKSUM_EN
  logic [31:0] chksum_q;

  // Running modulo-2^32 sum of every word written to the RAM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       chksum_q <= '0;
    else if (wr_en) chksum_q <= chksum_q + 32'(wr_data);
  end

  assign bus.chksum = chksum_q;
`else
  assign bus.chksum = '0;
`endif

  assign bus.rd_data      = rd_data_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.ram_feedback = ram_feedback_q;
  assign bus.fmap_done    = fmap_done_q;
  assign bus.overflow     = overflow_q;
endmodule

// File: tb/tb_fire6_squeeze_ram.sv
// tb_fire6_squeeze_ram: directed vectors against fire6_squeeze_ram.
module tb_fire6_squeeze_ram;
  localparam int WIDTH = 16;
  localparam int CH    = 64;
  localparam int WOUT  = 16;
  localparam int NPIX  = WOUT * WOUT;
  localparam int DEPTH = CH * NPIX;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   rf_cnt = 0;
  logic [31:0] sum_exp;

  fire6_squeeze_ram_if #(.WIDTH(WIDTH), .CH(CH), .WOUT(WOUT)) bus ();

  fire6_squeeze_ram #(.WIDTH(WIDTH), .CH(CH), .WOUT(WOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.ram_feedback) rf_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Drives one strobe; returns #1 after the accepting edge T
  task automatic send();
    bus.wr_sample = 1'b1;
    tick();
    bus.wr_sample = 1'b0;
    for (int c = 0; c < CH; c++) bus.ofm_in[c] = 16'h5555;
  endtask

  task automatic rd(input int a, output logic [31:0] d);
    bus.rd_en   = 1'b1;
    bus.rd_addr = 14'(a);
    tick();
    d = 32'(bus.rd_data);
    bus.rd_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    logic [31:0] d;
    bus.wr_sample = 1'b0;
    bus.rd_en     = 1'b0;
    bus.rd_addr   = '0;
    for (int c = 0; c < CH; c++) bus.ofm_in[c] = '0;

    // Reset state
    #12;
    chk("rst_rd_data",  32'(bus.rd_data), 0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 0);
    chk("rst_feedback", 32'(bus.ram_feedback), 0);
    chk("rst_done",     32'(bus.fmap_done), 0);
    chk("rst_overflow", 32'(bus.overflow), 0);
    chk("rst_chksum",   bus.chksum, 0);
    tick();
    rst = 1'b1;

    // Single pixel c+1, latency probe, dropped sample at T+10
    for (int c = 0; c < CH; c++) bus.ofm_in[c] = 16'(c + 1);
    send();                                  // edge T
    tick();                                  // T+1: word 0 written
    bus.rd_en = 1'b1; bus.rd_addr = '0;
    tick();                                  // T+2
    chk("p1_rd0", 32'(bus.rd_data), 1);
    chk("p1_rd_valid", 32'(bus.rd_valid), 1);
    bus.rd_en = 1'b0;
    tick();                                  // T+3
    chk("p1_rd_valid_low", 32'(bus.rd_valid), 0);
    chk("p1_rd_hold", 32'(bus.rd_data), 1);
    ticks(6);                                // after T+9
    for (int c = 0; c < CH; c++) bus.ofm_in[c] = 16'hAAAA;
    bus.wr_sample = 1'b1;
    tick();                                  // T+10, dropped
    bus.wr_sample = 1'b0;
    chk("p1_overflow", 32'(bus.overflow), 1);
    ticks(60);
    for (int a = 0; a < CH; a++) begin
      rd(a, d);
      chk($sformatf("p1_word[%0d]", a), d, 32'(a + 1));
    end
    chk("p1_feedback_cnt", 32'(rf_cnt), 0);
    chk("p1_done", 32'(bus.fmap_done), 0);
`ifdef FIRE6_SQZ_RAM_CHKSUM_EN
    chk("p1_chksum", bus.chksum, 2080);
`endif

    // Read-first: word 5 holds 0, then is rewritten with 0xBEEF
    do_reset();
    for (int c = 0; c < CH; c++) bus.ofm_in[c] = '0;
    send();
    ticks(70);
    do_reset();
    for (int c = 0; c < CH; c++) bus.ofm_in[c] = 16'(c);
    bus.ofm_in[5] = 16'hBEEF;
    send();                                  // edge T
    ticks(5);                                // after T+5, ch_cnt=5
    bus.rd_en = 1'b1; bus.rd_addr = 14'd5;
    tick();                                  // T+6: write and read collide
    chk("rf_old", 32'(bus.rd_data), 0);
    tick();                                  // T+7
    chk("rf_new", 32'(bus.rd_data), 32'hBEEF);
    bus.rd_en = 1'b0;
    ticks(70);

    // Reset mid-SHIFT at ch_cnt=20
    do_reset();
    rf_cnt = 0;
    for (int c = 0; c < CH; c++) bus.ofm_in[c] = 16'(16'h200 + c);
    send();                                  // edge T
    ticks(3);
    rd(0, d);                                // edge T+4
    chk("ab_rd_pre", d, 32'h200);
    bus.wr_sample = 1'b1;
    tick();                                  // T+5, dropped
    bus.wr_sample = 1'b0;
    chk("ab_ovf_pre", 32'(bus.overflow), 1);
    ticks(15);                               // after T+20, ch_cnt=20
    rst = 1'b0;
    #1;
    chk("ab_rd_data", 32'(bus.rd_data), 0);
    chk("ab_rd_valid", 32'(bus.rd_valid), 0);
    chk("ab_overflow", 32'(bus.overflow), 0);
    chk("ab_done", 32'(bus.fmap_done), 0);
    chk("ab_feedback", 32'(bus.ram_feedback), 0);
    chk("ab_chksum", bus.chksum, 0);
    tick();
    rst = 1'b1;
    for (int c = 0; c < CH; c++) bus.ofm_in[c] = 16'(16'h300 + c);
    send();
    ticks(66);
    for (int a = 0; a < CH; a++) begin
      rd(a, d);
      chk($sformatf("ab_word[%0d]", a), d, 32'(16'h300 + a));
    end

    // Full frame, pixel p channel c = p*64+c
    do_reset();
    rf_cnt = 0;
    for (int p = 0; p < NPIX; p++) begin
      for (int c = 0; c < CH; c++) bus.ofm_in[c] = 16'(p * CH + c);
      send();
      if (p == NPIX - 1) begin
        ticks(63);                           // after T+63
        chk("fr_fb_early", 32'(bus.ram_feedback), 0);
        chk("fr_done_early", 32'(bus.fmap_done), 0);
        tick();                              // T+64, final write
        chk("fr_fb_rise", 32'(bus.ram_feedback), 1);
        chk("fr_done_rise", 32'(bus.fmap_done), 1);
        tick();
        chk("fr_fb_fall", 32'(bus.ram_feedback), 0);
        chk("fr_done_hold", 32'(bus.fmap_done), 1);
      end else begin
        ticks(65);
      end
    end
    chk("fr_fb_cnt", 32'(rf_cnt), 1);
    chk("fr_overflow", 32'(bus.overflow), 0);
    sum_exp = 32'((DEPTH - 1) * DEPTH / 2);
`ifdef FIRE6_SQZ_RAM_CHKSUM_EN
    chk("fr_chksum", bus.chksum, sum_exp);
`endif
    bus.rd_en = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      bus.rd_addr = 14'(a);
      tick();
      chk($sformatf("fr_word[%0d]", a), 32'(bus.rd_data), 32'(a));
    end
    bus.rd_en = 1'b0;

    // Sample after frame completion is dropped
    for (int c = 0; c < CH; c++) bus.ofm_in[c] = 16'hFFFF;
    bus.wr_sample = 1'b1;
    tick();
    bus.wr_sample = 1'b0;
    ticks(70);
    chk("dn_overflow", 32'(bus.overflow), 1);
    chk("dn_done", 32'(bus.fmap_done), 1);
    chk("dn_fb_cnt", 32'(rf_cnt), 1);
    rd(0, d);
    chk("dn_word0", d, 0);
    rd(DEPTH - 1, d);
    chk("dn_word_last", d, 32'(DEPTH - 1));
`ifdef FIRE6_SQZ_RAM_CHKSUM_EN
    chk("dn_chksum", bus.chksum, sum_exp);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
